// File: rtl/bram_stream_reader.sv
// Burst reader for a registered-output block RAM: issues sequential reads and streams
// the words through a 2-entry skid buffer. Optional abort port: BRAM_STREAM_READER_ABORT_EN.
module bram_stream_reader #(
  parameter int  DATA_WIDTH    = 8,
  parameter int  DEPTH         = 256,
  localparam int ADDRESS_WIDTH = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] cmd_start_addr,
  input  logic [ADDRESS_WIDTH:0]   cmd_length,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  output logic [ADDRESS_WIDTH-1:0] rdaddress,
  input  logic [DATA_WIDTH-1:0]    q,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
`ifdef BRAM_STREAM_READER_ABORT_EN
  input  logic                     abort,
  output logic                     aborted,
`endif
  output logic                     done
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH:0]   remaining;
  logic                     pending;
  logic [1:0]               occ;
  logic [DATA_WIDTH-1:0]    tail;
  logic                     pop, push, accept, issue, last_pop, abort_hit;
  logic [2:0]               level;
  logic [ADDRESS_WIDTH-1:0] next_addr;

  assign pop       = out_valid & out_ready;
  assign push      = pending;
  assign accept    = cmd_valid & cmd_ready;
  // Words that will sit in the buffer once this edge's pop and the in-flight read land.
  assign level     = 3'(occ) + 3'(pending) - 3'(pop);
  assign issue     = (state == STREAM) && (remaining != '0) && (level < 3'd2);
  assign last_pop  = (state == DRAIN) && !pending && (occ == 2'd1) && pop;
  assign next_addr = (rdaddress == ADDRESS_WIDTH'(DEPTH - 1)) ? '0
                                                              : rdaddress + ADDRESS_WIDTH'(1);
  assign out_valid = (occ != 2'd0);

`ifdef BRAM_STREAM_READER_ABORT_EN
  assign abort_hit = abort & busy;

  always_ff @(posedge clock) begin
    if (reset) aborted <= 1'b0;
    else       aborted <= abort_hit;
  end
`else
  assign abort_hit = 1'b0;
`endif

  // NOTE: every register here is assigned with <= so all of them sample pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rdaddress <= '0;
      remaining <= '0;
      pending   <= 1'b0;
      occ       <= 2'd0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort_hit) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      remaining <= '0;
      pending   <= 1'b0;
      occ       <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            if (cmd_length == '0) begin
              done <= 1'b1;
            end else begin
              rdaddress <= cmd_start_addr;
              remaining <= cmd_length;
              busy      <= 1'b1;
              cmd_ready <= 1'b0;
              state     <= STREAM;
            end
          end
        end
        STREAM: begin
          if (issue && remaining == (ADDRESS_WIDTH + 1)'(1)) state <= DRAIN;
        end
        DRAIN: begin
          if (last_pop) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      pending <= issue;
      if (issue) begin
        remaining <= remaining - (ADDRESS_WIDTH + 1)'(1);
        rdaddress <= next_addr;
      end

      // Head entry: loaded from the RAM when it is (or is about to be) empty, else from tail.
      if ((occ == 2'd0) || (occ == 2'd1 && pop)) begin
        if (push) out_data <= q;
      end else if (occ == 2'd2 && pop) begin
        out_data <= tail;
      end
      occ <= occ + 2'(push) - 2'(pop);
    end
  end

  // NOTE: tail is only read when occupancy is 2, so it needs no reset.
  always_ff @(posedge clock) begin
    if (push && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop))) tail <= q;
  end

endmodule
